// File: rtl/writeback_regfile_if.sv
// Bundle between the memory/decode side and the write-back stage.
// Master drives M_* inputs, controls and read addresses; slave answers.
interface writeback_regfile_if;
    logic        W_stall;
    logic        W_bubble;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [63:0] rf_valA;
    logic [63:0] rf_valB;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [2:0]  cpu_stat;
    logic        halted;

    modport master (
        output W_stall, W_bubble,
        output M_stat, M_icode, M_dstE, M_dstM,
        output M_valE, m_valM,
        output d_srcA, d_srcB,
        input  rf_valA, rf_valB,
        input  W_stat, W_icode, W_dstE, W_dstM,
        input  W_valE, W_valM,
        input  cpu_stat, halted
    );

    modport slave (
        input  W_stall, W_bubble,
        input  M_stat, M_icode, M_dstE, M_dstM,
        input  M_valE, m_valM,
        input  d_srcA, d_srcB,
        output rf_valA, rf_valB,
        output W_stat, W_icode, W_dstE, W_dstM,
        output W_valE, W_valM,
        output cpu_stat, halted
    );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: W pipeline register, 16x64 register file,
// combinational decode read ports and the processor status FSM.
module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'd4095,
    parameter logic [3:0]  RNONE    = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_regfile_if.slave wb
);

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;
    localparam logic [3:0] INOP = 4'd1;

    typedef enum logic [1:0] {
        S_RUN,
        S_HALT,
        S_ERR
    } state_t;

    state_t      state_q;
    logic [2:0]  cpu_stat_q;
    logic        halted_q;

    logic [2:0]  w_stat_q, w_stat_d;
    logic [3:0]  w_icode_q, w_icode_d;
    logic [3:0]  w_dstE_q, w_dstE_d;
    logic [3:0]  w_dstM_q, w_dstM_d;
    logic [63:0] w_valE_q, w_valE_d;
    logic [63:0] w_valM_q, w_valM_d;

    logic [63:0] regs_q [16];
    logic        wr_en;

    assign wr_en = (state_q == S_RUN) && (w_stat_q == SAOK);

    // Status FSM: leave RUN when a halt or fault reaches W; sticky after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            cpu_stat_q <= SAOK;
            halted_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (w_stat_q == SHLT) begin
                        state_q    <= S_HALT;
                        cpu_stat_q <= w_stat_q;
                        halted_q   <= 1'b1;
                    end else if (w_stat_q == SADR || w_stat_q == SINS) begin
                        state_q    <= S_ERR;
                        cpu_stat_q <= w_stat_q;
                        halted_q   <= 1'b1;
                    end
                end
                S_HALT, S_ERR: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    // W register next state: frozen outside RUN, then bubble > stall > load.
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_dstE_d  = w_dstE_q;
        w_dstM_d  = w_dstM_q;
        w_valE_d  = w_valE_q;
        w_valM_d  = w_valM_q;
        if (state_q != S_RUN) begin
            w_stat_d = w_stat_q;
        end else if (wb.W_bubble) begin
            w_stat_d  = SAOK;
            w_icode_d = INOP;
            w_dstE_d  = RNONE;
            w_dstM_d  = RNONE;
            w_valE_d  = '0;
            w_valM_d  = '0;
        end else if (!wb.W_stall) begin
            w_stat_d  = wb.M_stat;
            w_icode_d = wb.M_icode;
            w_dstE_d  = wb.M_dstE;
            w_dstM_d  = wb.M_dstM;
            w_valE_d  = wb.M_valE;
            w_valM_d  = wb.m_valM;
        end
    end

    // W pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_stat_q  <= SAOK;
            w_icode_q <= INOP;
            w_dstE_q  <= RNONE;
            w_dstM_q  <= RNONE;
            w_valE_q  <= '0;
            w_valM_q  <= '0;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_dstE_q  <= w_dstE_d;
            w_dstM_q  <= w_dstM_d;
            w_valE_q  <= w_valE_d;
            w_valM_q  <= w_valM_d;
        end
    end

    // Register file commit; the later dstM write overrides dstE (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '{default: '0};
            regs_q[4] <= RSP_INIT;
        end else if (wr_en) begin
            if (w_dstE_q != RNONE) begin
                regs_q[w_dstE_q] <= w_valE_q;
            end
            if (w_dstM_q != RNONE) begin
                regs_q[w_dstM_q] <= w_valM_q;
            end
        end
    end

    // Read ports see pre-commit contents; decode forwards from W_* instead.
    always_comb begin
        wb.rf_valA = (wb.d_srcA == RNONE) ? '0 : regs_q[wb.d_srcA];
        wb.rf_valB = (wb.d_srcB == RNONE) ? '0 : regs_q[wb.d_srcB];
    end

    assign wb.W_stat   = w_stat_q;
    assign wb.W_icode  = w_icode_q;
    assign wb.W_dstE   = w_dstE_q;
    assign wb.W_dstM   = w_dstM_q;
    assign wb.W_valE   = w_valE_q;
    assign wb.W_valM   = w_valM_q;
    assign wb.cpu_stat = cpu_stat_q;
    assign wb.halted   = halted_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with a W-register scoreboard
// and a small architectural model of the register file and status.
module tb_writeback_regfile;

    logic clk;
    logic rst_n;

    writeback_regfile_if bus ();

    writeback_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [63:0] valE;
        logic [63:0] valM;
    } w_t;

    int tests;
    int fails;

    w_t          exp_q[$];
    w_t          m_w;
    logic        m_run;
    logic [2:0]  m_cpu;
    logic [63:0] m_rf [16];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_w.stat  = 3'd1;
        m_w.icode = 4'd1;
        m_w.dstE  = 4'hF;
        m_w.dstM  = 4'hF;
        m_w.valE  = '0;
        m_w.valM  = '0;
        m_run     = 1'b1;
        m_cpu     = 3'd1;
        for (int i = 0; i < 16; i++) m_rf[i] = (i == 4) ? 64'd4095 : 64'd0;
        exp_q.delete();
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm);
        bus.M_stat  = st;
        bus.M_icode = ic;
        bus.M_dstE  = de;
        bus.M_dstM  = dm;
        bus.M_valE  = ve;
        bus.m_valM  = vm;
    endtask

    task automatic check_w(input string tag);
        w_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_stat"}, 64'(bus.W_stat), 64'(e.stat));
        chk({tag, "_icode"}, 64'(bus.W_icode), 64'(e.icode));
        chk({tag, "_dstE"}, 64'(bus.W_dstE), 64'(e.dstE));
        chk({tag, "_dstM"}, 64'(bus.W_dstM), 64'(e.dstM));
        chk({tag, "_valE"}, bus.W_valE, e.valE);
        chk({tag, "_valM"}, bus.W_valM, e.valM);
        chk({tag, "_cpu"}, 64'(bus.cpu_stat), 64'(m_cpu));
        chk({tag, "_halt"}, 64'(bus.halted), 64'(!m_run));
    endtask

    // Advance one edge: predict commit, status and W, then compare.
    task automatic step(input string tag);
        w_t   nw;
        logic run_now;
        run_now = m_run;
        if (m_run && m_w.stat == 3'd1) begin
            if (m_w.dstE != 4'hF) m_rf[m_w.dstE] = m_w.valE;
            if (m_w.dstM != 4'hF) m_rf[m_w.dstM] = m_w.valM;
        end
        if (m_run && m_w.stat == 3'd2) begin
            m_run = 1'b0;
            m_cpu = 3'd2;
        end else if (m_run && (m_w.stat == 3'd3 || m_w.stat == 3'd4)) begin
            m_run = 1'b0;
            m_cpu = m_w.stat;
        end
        if (!run_now) begin
            nw = m_w;
        end else if (bus.W_bubble) begin
            nw.stat  = 3'd1;
            nw.icode = 4'd1;
            nw.dstE  = 4'hF;
            nw.dstM  = 4'hF;
            nw.valE  = '0;
            nw.valM  = '0;
        end else if (bus.W_stall) begin
            nw = m_w;
        end else begin
            nw.stat  = bus.M_stat;
            nw.icode = bus.M_icode;
            nw.dstE  = bus.M_dstE;
            nw.dstM  = bus.M_dstM;
            nw.valE  = bus.M_valE;
            nw.valM  = bus.m_valM;
        end
        m_w = nw;
        exp_q.push_back(nw);
        @(posedge clk);
        #1;
        check_w(tag);
    endtask

    task automatic rd(input string tag, input logic [3:0] r);
        bus.d_srcA = r;
        bus.d_srcB = r;
        #1;
        chk({tag, "_A"}, bus.rf_valA, (r == 4'hF) ? 64'd0 : m_rf[r]);
        chk({tag, "_B"}, bus.rf_valB, (r == 4'hF) ? 64'd0 : m_rf[r]);
    endtask

    task automatic nop_in();
        drive(3'd1, 4'd1, 4'hF, 4'hF, 64'd0, 64'd0);
        bus.W_stall  = 1'b0;
        bus.W_bubble = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.d_srcA = 4'd0;
        bus.d_srcB = 4'd0;
        nop_in();
        model_reset();
        #12;

        // Reset state, with constant expectations for every register.
        chk("rst_W_stat", 64'(bus.W_stat), 64'd1);
        chk("rst_W_icode", 64'(bus.W_icode), 64'd1);
        chk("rst_W_dstE", 64'(bus.W_dstE), 64'hF);
        chk("rst_W_dstM", 64'(bus.W_dstM), 64'hF);
        chk("rst_W_valE", bus.W_valE, 64'd0);
        chk("rst_W_valM", bus.W_valM, 64'd0);
        chk("rst_cpu", 64'(bus.cpu_stat), 64'd1);
        chk("rst_halt", 64'(bus.halted), 64'd0);
        for (int i = 0; i < 16; i++) begin
            bus.d_srcA = 4'(i);
            #1;
            chk($sformatf("rst_reg%0d", i), bus.rf_valA,
                (i == 4) ? 64'd4095 : 64'd0);
        end
        rst_n = 1'b1;

        // irmovq-style write to reg 2; old value visible before commit.
        drive(3'd1, 4'd3, 4'd2, 4'hF, 64'h1234, 64'd0);
        step("irm_w");
        nop_in();
        rd("irm_pre", 4'd2);
        step("irm_commit");
        rd("irm_post", 4'd2);
        chk("irm_fixed", bus.rf_valA, 64'h1234);

        // popq %rsp: dstE == dstM, load data wins.
        drive(3'd1, 4'hB, 4'd4, 4'd4, 64'd4103, 64'hDEAD);
        step("pop_w");
        nop_in();
        step("pop_commit");
        rd("pop_rsp", 4'd4);
        chk("pop_fixed", bus.rf_valA, 64'hDEAD);

        // Load W, then stall with different inputs for 3 cycles.
        drive(3'd1, 4'd6, 4'd7, 4'hF, 64'd55, 64'd0);
        step("stl_load");
        drive(3'd1, 4'd6, 4'd8, 4'd9, 64'd99, 64'd77);
        bus.W_stall = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("stl_%0d", i));
        bus.W_bubble = 1'b1;
        step("bub_stl");
        nop_in();
        step("bub_after");
        rd("stl_r7", 4'd7);
        rd("stl_r8", 4'd8);
        rd("stl_r9", 4'd9);
        rd("rnone", 4'hF);

        // Halt reaches W, the following write never commits.
        drive(3'd2, 4'd0, 4'hF, 4'hF, 64'd0, 64'd0);
        step("hlt_w");
        drive(3'd1, 4'd3, 4'd3, 4'hF, 64'd7, 64'd0);
        step("hlt_exit");
        step("hlt_hold0");
        step("hlt_hold1");
        rd("hlt_r3", 4'd3);
        chk("hlt_cpu_fixed", 64'(bus.cpu_stat), 64'd2);

        // Mid-cycle asynchronous reset.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_halt", 64'(bus.halted), 64'd0);
        chk("arst_cpu", 64'(bus.cpu_stat), 64'd1);
        chk("arst_W_icode", 64'(bus.W_icode), 64'd1);
        chk("arst_W_dstE", 64'(bus.W_dstE), 64'hF);
        rd("arst_r2", 4'd2);
        rd("arst_r4", 4'd4);
        #1;
        rst_n = 1'b1;
        nop_in();

        // Address fault: ERR, reg 5 untouched.
        drive(3'd3, 4'd3, 4'd5, 4'hF, 64'd9, 64'd0);
        step("err_w");
        nop_in();
        step("err_exit");
        step("err_hold");
        rd("err_r5", 4'd5);
        chk("err_cpu_fixed", 64'(bus.cpu_stat), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
